sfx_arbiter: RTL

- Sequences the single-voice audio processing unit: arbitrates eat, hit and die sound-event requests from game logic.
- Grants one at a time by fixed priority, holds the granted trigger for a per-sound number of frames, then inserts a silent gap.
- Sits between the collision detector outputs and the audio unit's saw/square/noise trigger inputs.
- Replaces direct per-event triggering, so overlapping events no longer stack on the audio unit.

---
 rtl/sfx_arbiter.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sfx_arbiter.sv
// sfx_arbiter: sound-event sequencer for the single-voice audio unit.
//
// Collects rising edges on the eat/hit/die request levels from the collision
// logic and grants them one at a time by fixed priority (die > hit > eat). The
// granted trigger is held for a per-sound number of video frames, then a silent
// gap of GAP_FRAMES frames is inserted before the next grant.
//
// Ports:
//   clk            in   system clock (pixel clock)
//   reset          in   synchronous, active-high reset
//   frame_end      in   one-cycle pulse per video frame (time base)
//   req_eat        in   level request, rising edge = eat event
//   req_hit        in   level request, rising edge = hit event
//   req_die        in   level request, rising edge = die event
//   saw_trigger    out  eat sound active
//   square_trigger out  hit sound active
//   noise_trigger  out  die sound active
//   busy           out  high while a sound or its gap is in progress
//   active_id      out  00 none, 01 eat, 10 hit, 11 die
//
// Build option:
//   SFX_PREEMPT_EN  when defined, a pending higher-priority sound aborts the
//                   one playing (no gap, aborted sound is dropped). When left
//                   undefined, a playing sound always runs to completion.
//
// Every *_FRAMES value must be below 2**CNT_W.

module sfx_arbiter #(
    parameter int unsigned EAT_FRAMES = 8,
    parameter int unsigned HIT_FRAMES = 12,
    parameter int unsigned DIE_FRAMES = 30,
    parameter int unsigned GAP_FRAMES = 2,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic       req_eat,
    input  logic       req_hit,
    input  logic       req_die,
    output logic       saw_trigger,
    output logic       square_trigger,
    output logic       noise_trigger,
    output logic       busy,
    output logic [1:0] active_id
);

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StGap
    } state_e;

    // The id encoding doubles as the priority order: a larger id wins.
    localparam logic [1:0] IdNone = 2'd0;
    localparam logic [1:0] IdEat  = 2'd1;
    localparam logic [1:0] IdHit  = 2'd2;
    localparam logic [1:0] IdDie  = 2'd3;

    // A zero-length sound still plays for one frame.
    localparam logic [CNT_W-1:0] EatLoad =
        (EAT_FRAMES == 0) ? CNT_W'(1) : CNT_W'(EAT_FRAMES);
    localparam logic [CNT_W-1:0] HitLoad =
        (HIT_FRAMES == 0) ? CNT_W'(1) : CNT_W'(HIT_FRAMES);
    localparam logic [CNT_W-1:0] DieLoad =
        (DIE_FRAMES == 0) ? CNT_W'(1) : CNT_W'(DIE_FRAMES);
    localparam logic [CNT_W-1:0] GapLoad = CNT_W'(GAP_FRAMES);

    // Request/pending vectors are ordered {die, hit, eat}.
    function automatic logic [2:0] id_mask(input logic [1:0] id);
        logic [2:0] m;
        case (id)
            IdEat:   m = 3'b001;
            IdHit:   m = 3'b010;
            IdDie:   m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] id_load(input logic [1:0] id);
        logic [CNT_W-1:0] v;
        case (id)
            IdHit:   v = HitLoad;
            IdDie:   v = DieLoad;
            default: v = EatLoad;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [1:0]       id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pend_q, pend_d;
    logic [2:0]       prev_q;

    logic             saw_q, saw_d;
    logic             square_q, square_d;
    logic             noise_q, noise_d;
    logic             busy_q, busy_d;
    logic [1:0]       active_id_q, active_id_d;

    logic [2:0]       req_vec;
    logic [2:0]       evt;
    logic [1:0]       pick_id;
    logic             retrig;
    logic             cnt_last;

    assign req_vec  = {req_die, req_hit, req_eat};
    assign evt      = req_vec & ~prev_q;
    assign cnt_last = (cnt_q <= CNT_W'(1));
    assign retrig   = |(evt & id_mask(id_q));

    // Highest-priority pending source; only registered pending flags are
    // considered, so an event arriving in a grant cycle waits one cycle.
    always_comb begin
        pick_id = IdNone;
        if (pend_q[2]) begin
            pick_id = IdDie;
        end else if (pend_q[1]) begin
            pick_id = IdHit;
        end else if (pend_q[0]) begin
            pick_id = IdEat;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q | evt;

        case (state_q)
            StIdle: begin
                if (pick_id != IdNone) begin
                    // frame_end in this cycle is ignored: the fresh count
                    // starts on the next frame.
                    state_d = StPlay;
                    id_d    = pick_id;
                    cnt_d   = id_load(pick_id);
                    pend_d  = (pend_q & ~id_mask(pick_id)) | evt;
                end
            end

            StPlay: begin
                // A new edge of the playing source extends the sound
                // instead of queueing a second copy.
                pend_d = pend_q | (evt & ~id_mask(id_q));
`ifdef SFX_PREEMPT_EN
                if (pick_id > id_q) begin
                    // Abort the current sound outright; it is not re-queued.
                    // A same-cycle edge of the aborted source is kept pending.
                    id_d   = pick_id;
                    cnt_d  = id_load(pick_id);
                    pend_d = (pend_q & ~id_mask(pick_id)) | evt;
                end else
`endif
                if (retrig) begin
                    cnt_d = id_load(id_q);
                end else if (frame_end) begin
                    if (cnt_last) begin
                        id_d = IdNone;
                        if (GAP_FRAMES > 0) begin
                            state_d = StGap;
                            cnt_d   = GapLoad;
                        end else begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            StGap: begin
                if (frame_end) begin
                    if (cnt_last) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = StIdle;
                id_d    = IdNone;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered alongside the state they decode, so they change
    // on the same edge as the state transition.
    always_comb begin
        saw_d       = (state_d == StPlay) && (id_d == IdEat);
        square_d    = (state_d == StPlay) && (id_d == IdHit);
        noise_d     = (state_d == StPlay) && (id_d == IdDie);
        busy_d      = (state_d != StIdle);
        active_id_d = (state_d == StPlay) ? id_d : IdNone;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            id_q        <= IdNone;
            cnt_q       <= '0;
            pend_q      <= '0;
            // A request already high during reset must not count as an event.
            prev_q      <= req_vec;
            saw_q       <= 1'b0;
            square_q    <= 1'b0;
            noise_q     <= 1'b0;
            busy_q      <= 1'b0;
            active_id_q <= IdNone;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            prev_q      <= req_vec;
            saw_q       <= saw_d;
            square_q    <= square_d;
            noise_q     <= noise_d;
            busy_q      <= busy_d;
            active_id_q <= active_id_d;
        end
    end

    assign saw_trigger    = saw_q;
    assign square_trigger = square_q;
    assign noise_trigger  = noise_q;
    assign busy           = busy_q;
    assign active_id      = active_id_q;

endmodule
